// File: rtl/rr_arb8.sv
// rr_arb8: round-robin arbiter for N requesters with registered one-hot grant.
// The search for the next winner starts just after the last winner (ptr_q).
// A grant is held until done, until the holder drops its request, or (with
// ARB_TIMEOUT_EN defined) until the holder has used up MAX_HOLD cycles while
// someone else is waiting.
module rr_arb8 #(
   parameter int N        = 8,
   parameter int IDW      = 3,
   parameter int MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_vld,
   output logic           to_pls
);

   if (N != (1 << IDW) || N < 2 || N > 16 || MAX_HOLD < 2) begin : g_param_chk
      $error("rr_arb8: inconsistent N/IDW/MAX_HOLD");
   end

   typedef enum logic {IDLE, GRANT} state_e;

   state_e         state_q;
   logic [N-1:0]   gnt_q;
   logic [IDW-1:0] gnt_id_q;
   logic [IDW-1:0] ptr_q;

   logic [N-1:0]   cand;
   logic           pick_vld;
   logic [IDW-1:0] pick_id;
   logic [IDW-1:0] idx;
   logic           holder_req;
   logic           tmo;
   logic           rel;

   // Candidates: in GRANT the holder is excluded so release hands over to someone else.
   always_comb begin
      cand = (state_q == GRANT) ? (req & ~gnt_q) : req;
   end

   // Rotated priority search: ptr_q+1 first, ptr_q itself last.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = '0;
      for (int i = 1; i <= N; i++) begin
         idx = ptr_q + IDW'(i);
         if (!pick_vld && cand[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

   assign holder_req = req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
   logic [$clog2(MAX_HOLD)-1:0] cnt_q;
   logic                        to_pls_q;

   // Forced release only when the hold budget is spent and a new grant is possible.
   always_comb begin
      tmo = (state_q == GRANT) && en && pick_vld &&
            (cnt_q == ($clog2(MAX_HOLD))'(MAX_HOLD - 1));
   end

   assign to_pls = to_pls_q;
`else
   assign tmo    = 1'b0;
   assign to_pls = 1'b0;
`endif

   assign rel = done | ~holder_req | tmo;

   // Arbiter FSM: grant registers, pointer and (optional) hold counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         ptr_q    <= IDW'(N - 1);
`ifdef ARB_TIMEOUT_EN
         cnt_q    <= '0;
         to_pls_q <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         to_pls_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (en && pick_vld) begin
                  state_q  <= GRANT;
                  gnt_q    <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                  gnt_id_q <= pick_id;
                  ptr_q    <= pick_id;
`ifdef ARB_TIMEOUT_EN
                  cnt_q    <= '0;
`endif
               end
            end
            GRANT: begin
               if (rel) begin
                  if (en && pick_vld) begin
                     // back-to-back hand-over, no idle bubble
                     gnt_q    <= {{(N-1){1'b0}}, 1'b1} << pick_id;
                     gnt_id_q <= pick_id;
                     ptr_q    <= pick_id;
`ifdef ARB_TIMEOUT_EN
                     cnt_q    <= '0;
                     to_pls_q <= tmo & ~done & holder_req;
`endif
                  end else begin
                     state_q  <= IDLE;
                     gnt_q    <= '0;
                     gnt_id_q <= '0;
                  end
               end
`ifdef ARB_TIMEOUT_EN
               else if (cnt_q != ($clog2(MAX_HOLD))'(MAX_HOLD - 1)) begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = |gnt_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8; timeout steps run only when ARB_TIMEOUT_EN is defined.
module tb_rr_arb8;

`ifdef ARB_TIMEOUT_EN
   localparam int MH = 4;
`else
   localparam int MH = 16;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] req = '0;
   logic       done = 1'b0;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_vld;
   logic       to_pls;

   int checks = 0;
   int failures = 0;

   rr_arb8 #(.N(8), .IDW(3), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld), .to_pls(to_pls)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_g(input string tag, input logic [7:0] eg, input logic [2:0] eid);
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
      chk({tag, ".vld"}, 32'(gnt_vld), 32'(eg != 0));
   endtask

   initial begin
      // reset state
      #2;
      chk_g("reset", 8'h00, 3'd0);
      chk("reset.to", 32'(to_pls), 32'd0);
      tick();
      rst_n = 1'b1;

      // single request then done
      req = 8'h04; en = 1'b1;
      tick();
      chk_g("single", 8'h04, 3'd2);
      done = 1'b1; req = 8'h00;
      tick();
      chk_g("single.rel", 8'h00, 3'd0);
      done = 1'b0;

      // fairness from a fresh pointer
      rst_n = 1'b0; #1; rst_n = 1'b1;
      req = 8'hFF; done = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk_g($sformatf("fair%0d", i), 8'h01 << (i % 8), 3'(i % 8));
      end
      req = 8'h00; done = 1'b0;
      tick();
      chk_g("fair.idle", 8'h00, 3'd0);

      // wrap: holder 3, then 7, 0, 3
      req = 8'h08;
      tick();
      chk_g("wrap.h3", 8'h08, 3'd3);
      req = 8'h89; done = 1'b1;
      tick();
      chk_g("wrap.7", 8'h80, 3'd7);
      tick();
      chk_g("wrap.0", 8'h01, 3'd0);
      tick();
      chk_g("wrap.3", 8'h08, 3'd3);
      req = 8'h00; done = 1'b0;
      tick();
      chk_g("wrap.idle", 8'h00, 3'd0);

      // en low blocks new grants
      en = 1'b0; req = 8'h0F;
      tick();
      tick();
      chk_g("en0", 8'h00, 3'd0);

      // en dropped mid-grant keeps holder until done
      en = 1'b1; req = 8'h02;
      tick();
      chk_g("hold1", 8'h02, 3'd1);
      en = 1'b0; req = 8'h0F;
      for (int i = 0; i < 3; i++) tick();
      chk_g("hold1.en0", 8'h02, 3'd1);
      done = 1'b1;
      tick();
      chk_g("hold1.done", 8'h00, 3'd0);
      done = 1'b0;

      // abandon: holder drops its bit with another pending -> back-to-back
      en = 1'b1; req = 8'h20;
      tick();
      chk_g("abn.h5", 8'h20, 3'd5);
      req = 8'h40;
      tick();
      chk_g("abn.6", 8'h40, 3'd6);
      req = 8'h00;
      tick();
      chk_g("abn.idle", 8'h00, 3'd0);

      // async reset mid-grant
      req = 8'h10;
      tick();
      chk_g("rst.h4", 8'h10, 3'd4);
      #2 rst_n = 1'b0;
      #1;
      chk_g("rst.async", 8'h00, 3'd0);
      rst_n = 1'b1;
      req = 8'hFF;
      tick();
      chk_g("rst.first", 8'h01, 3'd0);

      // lone holder keeps grant, no pulse
      req = 8'h01;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i % 5 == 4) begin
            chk_g($sformatf("lone%0d", i), 8'h01, 3'd0);
            chk($sformatf("lone%0d.to", i), 32'(to_pls), 32'd0);
         end
      end

`ifdef ARB_TIMEOUT_EN
      // forced release after MAX_HOLD cycles
      rst_n = 1'b0; #1; rst_n = 1'b1;
      req = 8'h03;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_g($sformatf("tmo.hold%0d", i), 8'h01, 3'd0);
         chk($sformatf("tmo.hold%0d.to", i), 32'(to_pls), 32'd0);
      end
      tick();
      chk_g("tmo.new", 8'h02, 3'd1);
      chk("tmo.pls", 32'(to_pls), 32'd1);
      tick();
      chk_g("tmo.after", 8'h02, 3'd1);
      chk("tmo.pls0", 32'(to_pls), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters (default 8).
- Internally it uses rotated priority encoding (search for the first set request bit starting after the last winner), then registers the winner and holds it.
- Outputs a one-hot grant, the binary grant index and a valid flag. These feed the mux/select of the shared datapath.
- Sits between requester agents and the shared unit. It adds sequencing, fairness and grant hold that a pure combinational encoder lacks.

Parameters:
- N, 8, number of requesters (power of two, 2..16)
- IDW, 3, width of grant index, equals log2(N)
- MAX_HOLD, 16, max cycles one holder may keep the grant (used only with ARB_TIMEOUT_EN; min 2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  arbitration enable; low blocks new grants only
- req  input  N  request vector, bit i = requester i, level-sensitive
- done  input  1  current holder releases grant this cycle
- gnt  output  N  one-hot grant, registered
- gnt_id  output  IDW  binary index of holder, registered; 0 when idle
- gnt_vld  output  1  high when any grant is active (= |gnt)
- to_pls  output  1  one-cycle pulse on forced release; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, gnt_id=0, gnt_vld=0, to_pls=0.
  - State=IDLE, ptr=N-1, so requester 0 is highest priority first. Hold counter = 0.
- Arbitration function:
  - Search req from index ptr+1 upward, wrapping modulo N; the first set bit wins.
  - ptr itself is the lowest priority. All index arithmetic wraps modulo N.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en && |req, go to GRANT next edge with gnt=onehot(winner), gnt_id=winner, ptr<=winner.
  - Latency: req sampled at edge k gives gnt visible after edge k (1 cycle).
- GRANT, release condition:
  - rel = done, OR req[gnt_id]==0 (abandon), OR forced timeout.
- GRANT, outcomes:
  - No rel: hold gnt/gnt_id unchanged. Changes on req from others are ignored.
  - rel with en=1 and another request pending (holder's bit excluded on this cycle): re-arbitrate the same edge and grant the new winner back-to-back, with no idle bubble. ptr<=new winner.
  - rel with no other request, or en=0: go to IDLE, gnt=0, gnt_id=0.
- done is ignored in IDLE.
- en dropping mid-grant does not revoke the current grant. Only new grants are blocked.
- Holder re-requesting on the cycle after release competes normally. It has the lowest priority because ptr=holder.
- At most one gnt bit is high at any time. gnt_vld equals |gnt on every cycle.
- Reset mid-grant clears all outputs immediately (asynchronously) and restores ptr=N-1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - Hold counter counts cycles in GRANT. It clears on every new grant.
  - When it reaches MAX_HOLD-1 and another requester is pending, release is forced: to_pls=1 for one cycle, coincident with the new grant.
  - If no other request is pending, the counter saturates and the holder keeps the grant.
- Undefined: no counter, to_pls constant 0, grant held until done or abandon.

Test Plan:
- Reset: assert rst_n=0 mid-grant (gnt=0x10) -> gnt=0x00, gnt_id=0, gnt_vld=0 with no clock edge; first grant after reset with req=0xFF -> gnt=0x01.
- Single request: req=0x04, en=1 -> one cycle later gnt=0x04, gnt_id=2, gnt_vld=1; done=1 for one cycle -> next cycle gnt=0x00, gnt_vld=0.
- Fairness: req=0xFF held, done=1 every grant cycle -> gnt_id sequence 0,1,2,3,4,5,6,7,0 with no idle cycles.
- Wrap/priority: holder gnt_id=3, req=0x89, done=1 -> next gnt_id=7, then on done gnt_id=0, then 3.
- Enable/abandon:
  - en=0 with req=0x0F -> gnt stays 0.
  - With holder 1 and en dropped to 0 -> gnt stays 0x02 until done.
  - Holder dropping req bit without done -> release next edge.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=0x03, done=0 -> gnt=0x01 for 4 cycles, then to_pls=1 with gnt=0x02. Same bench with req=0x01 only -> gnt=0x01 indefinitely, to_pls=0.
